// File: rtl/dma_ctrl_if.sv
// Bus bundle between the 6502 core, the DMA controller and the memory decode.
// The slave modport is the DMA controller's view; master is the surrounding system.
interface dma_ctrl_if;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_dout;
    logic        i_cpu_we;
    logic        o_cpu_rdy;
    logic [7:0]  i_mem_din;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_dout;
    logic        o_mem_we;
    logic        o_busy;
    logic        o_done;

    modport slave (
        input  i_cpu_addr, i_cpu_dout, i_cpu_we, i_mem_din,
        output o_cpu_rdy, o_mem_addr, o_mem_dout, o_mem_we, o_busy, o_done
    );

    modport master (
        output i_cpu_addr, i_cpu_dout, i_cpu_we, i_mem_din,
        input  o_cpu_rdy, o_mem_addr, o_mem_dout, o_mem_we, o_busy, o_done
    );
endinterface

// File: rtl/dma_ctrl.sv
// Page-copy DMA controller: snoops a CPU trigger write, stalls the 6502 via RDY,
// copies LEN bytes of a page into a fixed destination, then hands the bus back.
module dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DST_ADDR  = 16'h2004,
    parameter int unsigned LEN       = 256
) (
    input  logic      i_clk,
    input  logic      i_rst,
    dma_ctrl_if.slave bus
);
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic       done_q, done_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_cpu_we && (bus.i_cpu_addr == TRIG_ADDR)) begin
                    state_d = StHalt;
                    page_d  = bus.i_cpu_dout;
                    idx_d   = 8'h00;
                end
            end
            // RDY is ignored by the 6502 on writes; wait for the first stalled read.
            StHalt: begin
                if (!bus.i_cpu_we) state_d = StAlign;
            end
            StAlign: state_d = StRead;
            StRead:  state_d = StWrite;
            StWrite: begin
                if (idx_q == LAST_IDX) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StRead;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.o_mem_addr = bus.i_cpu_addr;
        bus.o_mem_dout = bus.i_cpu_dout;
        bus.o_mem_we   = bus.i_cpu_we;
        unique case (state_q)
            StIdle, StHalt: ;
            StAlign: begin
                bus.o_mem_addr = {page_q, 8'h00};
                bus.o_mem_we   = 1'b0;
            end
            StRead: begin
                bus.o_mem_addr = {page_q, idx_q};
                bus.o_mem_we   = 1'b0;
            end
            StWrite: begin
                bus.o_mem_addr = DST_ADDR;
                bus.o_mem_dout = bus.i_mem_din;
                bus.o_mem_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // RDY comes from registered state only, never from the CPU bus.
    assign bus.o_cpu_rdy = (state_q == StIdle);
    assign bus.o_busy    = (state_q != StIdle);
    assign bus.o_done    = done_q;
endmodule
